// File: rtl/tree_node_dispatch.sv
// tree_node_dispatch: hierarchy node that takes one tagged job from a parent,
// starts either every child (broadcast) or the next child in round-robin order,
// collects per-child completions with a timeout, and returns one response.
module tree_node_dispatch #(
    parameter int NUM_CHILDREN = 5,
    parameter int TAG_W        = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [TAG_W-1:0]        req_tag,
    input  logic                    req_bcast,
    output logic [NUM_CHILDREN-1:0] child_start,
    output logic [TAG_W-1:0]        child_tag,
    input  logic [NUM_CHILDREN-1:0] child_done,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic                    rsp_timeout,
    output logic [NUM_CHILDREN-1:0] rsp_mask,
    output logic                    busy,
    output logic [7:0]              timeout_cnt
);

    localparam int PW = $clog2(NUM_CHILDREN);
    localparam int TW = 16;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPATCH = 2'd1;
    localparam logic [1:0] S_WAIT     = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    localparam logic [NUM_CHILDREN-1:0] LSB_ONE  = {{(NUM_CHILDREN-1){1'b0}}, 1'b1};
    localparam logic [NUM_CHILDREN-1:0] ALL_ONES = {NUM_CHILDREN{1'b1}};
    localparam logic [PW-1:0]           RR_LAST  = PW'(NUM_CHILDREN - 1);
    localparam logic [TW-1:0]           TMO_LOAD = TW'(TIMEOUT);

    logic [1:0]              state_q, state_d;
    logic [PW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic                    bcast_q, bcast_d;
    logic [NUM_CHILDREN-1:0] target_q, target_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [NUM_CHILDREN-1:0] done_seen_q, done_seen_d;
    logic [7:0]              timeout_cnt_q, timeout_cnt_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    logic [NUM_CHILDREN-1:0] rr_onehot;
    logic [NUM_CHILDREN-1:0] done_now;

    // Round-robin target and the completion set as it would stand after this cycle.
    always_comb begin
        rr_onehot = LSB_ONE << rr_ptr_q;
        done_now  = done_seen_q | (child_done & target_q);
    end

    // Next-state logic: accept, dispatch, collect completions/timeout, respond.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        tag_d         = tag_q;
        bcast_d       = bcast_q;
        target_d      = target_q;
        timer_d       = timer_q;
        done_seen_d   = done_seen_q;
        timeout_cnt_d = timeout_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    tag_d    = req_tag;
                    bcast_d  = req_bcast;
                    target_d = req_bcast ? ALL_ONES : rr_onehot;
                    state_d  = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                done_seen_d = '0;
                timer_d     = TMO_LOAD;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                done_seen_d = done_now;
                // Completion is checked first so a last done on the final
                // timer cycle is reported as a normal finish.
                if (done_now == target_q) begin
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RESP;
                end else if (timer_q == '0) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                    if (timeout_cnt_q != 8'hFF) begin
                        timeout_cnt_d = timeout_cnt_q + 8'd1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    // Only round-robin jobs consume a pointer slot, timed out or not.
                    if (!bcast_q) begin
                        rr_ptr_d = (rr_ptr_q == RR_LAST) ? '0 : rr_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            tag_q         <= '0;
            bcast_q       <= 1'b0;
            target_q      <= '0;
            timer_q       <= '0;
            done_seen_q   <= '0;
            timeout_cnt_q <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            tag_q         <= tag_d;
            bcast_q       <= bcast_d;
            target_q      <= target_d;
            timer_q       <= timer_d;
            done_seen_q   <= done_seen_d;
            timeout_cnt_q <= timeout_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Outputs decode from registered state, so reset clears them immediately.
    always_comb begin
        req_ready   = (state_q == S_IDLE);
        busy        = (state_q != S_IDLE);
        child_start = (state_q == S_DISPATCH) ? target_q : '0;
        child_tag   = tag_q;
        rsp_valid   = (state_q == S_RESP);
        rsp_tag     = tag_q;
        rsp_mask    = done_seen_q;
        rsp_timeout = rsp_timeout_q;
        timeout_cnt = timeout_cnt_q;
    end

endmodule
